// File: rtl/l2_train_sequencer_if.sv
// l2_train_sequencer_if: update-command handshake between the sequencer and the L2 datapath
interface l2_train_sequencer_if;
    logic       upd_valid;
    logic [1:0] upd_kind;
    logic [2:0] upd_neuron;
    logic       upd_ready;

    modport master (output upd_valid, upd_kind, upd_neuron, input upd_ready);
    modport slave  (input upd_valid, upd_kind, upd_neuron, output upd_ready);
endinterface

// File: rtl/l2_train_sequencer.sv
// l2_train_sequencer: sequences supervised and unsupervised training commands for the 3-neuron L2 layer
module l2_train_sequencer #(
    parameter int p_wait_clks = 7,
    parameter int p_samples   = 16,
    parameter int p_epochs    = 8,
    parameter int p_cnt_w     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [2:0]           i_label,
    input  logic [2:0]           i_l2_spikeout,
    l2_train_sequencer_if.master upd,
    output logic                 o_window_open,
    output logic                 o_endof_epochs,
    output logic                 o_busy,
    output logic [p_cnt_w-1:0]   o_sample_cnt,
    output logic [p_cnt_w-1:0]   o_epoch_cnt,
    output logic                 o_err_multi
);
    localparam int ww = (p_wait_clks > 1) ? $clog2(p_wait_clks) : 1;
    localparam logic [ww-1:0]      win_last    = ww'(p_wait_clks - 1);
    localparam logic [p_cnt_w-1:0] sample_last = p_cnt_w'(p_samples - 1);
    localparam logic [p_cnt_w-1:0] epoch_last  = p_cnt_w'(p_epochs - 1);

    if (p_wait_clks < 1 || p_samples < 1 || p_epochs < 1 ||
        p_samples > 2**p_cnt_w || p_epochs > 2**p_cnt_w) begin : g_bad_params
        $error("l2_train_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WINDOW, S_ISSUE, S_DONE} state_t;

    state_t             state, state_d;
    logic [ww-1:0]      win_cnt, win_cnt_d;
    logic [2:0]         label_q, label_d, winner_q, winner_d, neuron_q, neuron_d;
    logic [1:0]         kind_q, kind_d;
    logic [p_cnt_w-1:0] sample_q, sample_d, epoch_q, epoch_d;
    logic               err_q, err_d;

    logic label_ok, spike_ok, multi;
    assign label_ok = $onehot(i_label);
    assign spike_ok = $onehot(i_l2_spikeout);
    assign multi    = ((i_label & (i_label - 3'd1)) != 3'd0) ||
                      ((i_l2_spikeout & (i_l2_spikeout - 3'd1)) != 3'd0);

    // State register; reset abandons any window or pending command
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // Window counter, latched label/winner, command fields, counters and error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win_cnt  <= '0;
            label_q  <= '0;
            winner_q <= '0;
            kind_q   <= '0;
            neuron_q <= '0;
            sample_q <= '0;
            epoch_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            win_cnt  <= win_cnt_d;
            label_q  <= label_d;
            winner_q <= winner_d;
            kind_q   <= kind_d;
            neuron_q <= neuron_d;
            sample_q <= sample_d;
            epoch_q  <= epoch_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath decisions; multi-hot inputs only flagged where inputs are examined
    always_comb begin
        state_d   = state;
        win_cnt_d = win_cnt;
        label_d   = label_q;
        winner_d  = winner_q;
        kind_d    = kind_q;
        neuron_d  = neuron_q;
        sample_d  = sample_q;
        epoch_d   = epoch_q;
        err_d     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    sample_d = '0;
                    epoch_d  = '0;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                err_d = multi;
                if (label_ok) begin
                    label_d   = i_label;
                    winner_d  = spike_ok ? i_l2_spikeout : 3'b000;
                    win_cnt_d = '0;
                    state_d   = S_WINDOW;
                end else if (spike_ok) begin
                    kind_d   = 2'b11;
                    neuron_d = i_l2_spikeout;
                    state_d  = S_ISSUE;
                end
            end
            S_WINDOW: begin
                err_d     = multi;
                win_cnt_d = win_cnt + 1'b1;
                winner_d  = (winner_q == 3'b000 && spike_ok) ? i_l2_spikeout : winner_q;
                if (win_cnt == win_last) begin
                    kind_d   = (winner_d == label_q) ? 2'b01 : 2'b10;
                    neuron_d = label_q;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (upd.upd_ready) begin
                    state_d = S_ARMED;
                    if (kind_q != 2'b11) begin
                        if (sample_q == sample_last) begin
                            sample_d = '0;
                            epoch_d  = (epoch_q == '1) ? epoch_q : epoch_q + 1'b1;
                            state_d  = (epoch_q == epoch_last) ? S_DONE : S_ARMED;
                        end else begin
                            sample_d = sample_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign upd.upd_valid  = (state == S_ISSUE);
    assign upd.upd_kind   = kind_q;
    assign upd.upd_neuron = neuron_q;
    assign o_window_open  = (state == S_WINDOW);
    assign o_endof_epochs = (state == S_DONE);
    assign o_busy         = (state == S_ARMED) || (state == S_WINDOW) || (state == S_ISSUE);
    assign o_sample_cnt   = sample_q;
    assign o_epoch_cnt    = epoch_q;
    assign o_err_multi    = err_q;
endmodule

// File: tb/tb_l2_train_sequencer.sv
// tb_l2_train_sequencer: directed checks of the L2 training sequencer with two samples per epoch and two epochs
module tb_l2_train_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] label = 3'b000;
    logic [2:0] spike = 3'b000;
    logic       window_open, endof_epochs, busy, err_multi;
    logic [7:0] sample_cnt, epoch_cnt;
    int         checks = 0;
    int         errors = 0;

    l2_train_sequencer_if bus ();

    l2_train_sequencer #(
        .p_wait_clks(7), .p_samples(2), .p_epochs(2), .p_cnt_w(8)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_label(label),
        .i_l2_spikeout(spike),
        .upd(bus),
        .o_window_open(window_open),
        .o_endof_epochs(endof_epochs),
        .o_busy(busy),
        .o_sample_cnt(sample_cnt),
        .o_epoch_cnt(epoch_cnt),
        .o_err_multi(err_multi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cmd(input string tag, input logic v, input logic [1:0] k, input logic [2:0] n);
        chk({tag, "_valid"}, {31'd0, bus.upd_valid}, {31'd0, v});
        chk({tag, "_kind"}, {30'd0, bus.upd_kind}, {30'd0, k});
        chk({tag, "_neuron"}, {29'd0, bus.upd_neuron}, {29'd0, n});
    endtask

    initial begin
        bus.upd_ready = 1'b0;
        repeat (2) tick();
        chk_cmd("rst", 1'b0, 2'b00, 3'b000);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_window", {31'd0, window_open}, 0);
        chk("rst_endof", {31'd0, endof_epochs}, 0);
        chk("rst_err", {31'd0, err_multi}, 0);
        chk("rst_sample", {24'd0, sample_cnt}, 0);
        chk("rst_epoch", {24'd0, epoch_cnt}, 0);
        rst_n = 1'b1;
        tick();
        label = 3'b001;
        tick();
        label = 3'b000;
        chk("idle_ignores_label", {31'd0, window_open}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 1);

        // reward: label 001, matching spike three cycles later, ready tied high
        bus.upd_ready = 1'b1;
        label = 3'b001;
        tick();
        label = 3'b000;
        chk("t1_window", {31'd0, window_open}, 1);
        tick();
        tick();
        spike = 3'b001;
        tick();
        spike = 3'b000;
        repeat (3) tick();
        chk("t1_valid_early", {31'd0, bus.upd_valid}, 0);
        chk("t1_window_last", {31'd0, window_open}, 1);
        tick();
        chk_cmd("t1_cmd", 1'b1, 2'b01, 3'b001);
        tick();
        chk("t1_valid_done", {31'd0, bus.upd_valid}, 0);
        chk("t1_sample", {24'd0, sample_cnt}, 1);

        // decay: label 010, no spike, ready withheld for five cycles
        bus.upd_ready = 1'b0;
        label = 3'b010;
        tick();
        label = 3'b000;
        repeat (6) tick();
        chk("t2_valid_early", {31'd0, bus.upd_valid}, 0);
        tick();
        chk_cmd("t2_cmd0", 1'b1, 2'b10, 3'b010);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_cmd("t2_hold", 1'b1, 2'b10, 3'b010);
            chk("t2_hold_sample", {24'd0, sample_cnt}, 1);
        end
        bus.upd_ready = 1'b1;
        tick();
        chk("t2_valid_done", {31'd0, bus.upd_valid}, 0);
        chk("t2_sample_wrap", {24'd0, sample_cnt}, 0);
        chk("t2_epoch", {24'd0, epoch_cnt}, 1);
        chk("t2_busy", {31'd0, busy}, 1);

        // unsupervised: spike 100 without label
        spike = 3'b100;
        tick();
        spike = 3'b000;
        chk_cmd("t3_cmd", 1'b1, 2'b11, 3'b100);
        chk("t3_window", {31'd0, window_open}, 0);
        tick();
        chk("t3_valid_done", {31'd0, bus.upd_valid}, 0);
        chk("t3_sample", {24'd0, sample_cnt}, 0);
        chk("t3_epoch", {24'd0, epoch_cnt}, 1);

        // first winner wins: label 001, spike 010 then 001
        label = 3'b001;
        tick();
        label = 3'b000;
        chk("t4_window", {31'd0, window_open}, 1);
        spike = 3'b010;
        tick();
        spike = 3'b001;
        tick();
        spike = 3'b000;
        repeat (4) tick();
        chk("t4_valid_early", {31'd0, bus.upd_valid}, 0);
        tick();
        chk_cmd("t4_cmd", 1'b1, 2'b10, 3'b001);
        tick();
        chk("t4_sample", {24'd0, sample_cnt}, 1);

        // multi-hot label in ARMED
        label = 3'b011;
        tick();
        label = 3'b000;
        chk("t5_err", {31'd0, err_multi}, 1);
        chk("t5_window", {31'd0, window_open}, 0);
        tick();
        chk("t5_err_pulse", {31'd0, err_multi}, 0);
        chk("t5_no_window", {31'd0, window_open}, 0);
        chk("t5_no_valid", {31'd0, bus.upd_valid}, 0);

        // last sample: spike with the label counts as winner, finishes the second epoch
        label = 3'b100;
        spike = 3'b100;
        tick();
        label = 3'b000;
        spike = 3'b000;
        chk("t6_window", {31'd0, window_open}, 1);
        repeat (7) tick();
        chk_cmd("t6_cmd", 1'b1, 2'b01, 3'b100);
        tick();
        chk("t6_sample", {24'd0, sample_cnt}, 0);
        chk("t6_epoch", {24'd0, epoch_cnt}, 2);
        chk("t6_endof", {31'd0, endof_epochs}, 1);
        chk("t6_busy", {31'd0, busy}, 0);
        label = 3'b001;
        tick();
        label = 3'b000;
        chk("done_ignores_label", {31'd0, window_open}, 0);
        chk("done_sticky", {31'd0, endof_epochs}, 1);
        chk("done_epoch_hold", {24'd0, epoch_cnt}, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_endof", {31'd0, endof_epochs}, 0);
        chk("restart_epoch", {24'd0, epoch_cnt}, 0);
        chk("restart_sample", {24'd0, sample_cnt}, 0);
        chk("restart_busy", {31'd0, busy}, 1);

        // reset during ISSUE
        bus.upd_ready = 1'b0;
        spike = 3'b010;
        tick();
        spike = 3'b000;
        chk_cmd("t7_issue", 1'b1, 2'b11, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cmd("t7_rst", 1'b0, 2'b00, 3'b000);
        chk("t7_rst_busy", {31'd0, busy}, 0);
        tick();
        rst_n = 1'b1;
        bus.upd_ready = 1'b1;
        tick();
        chk_cmd("t7_after", 1'b0, 2'b00, 3'b000);
        chk("t7_after_busy", {31'd0, busy}, 0);
        chk("t7_after_endof", {31'd0, endof_epochs}, 0);
        spike = 3'b001;
        tick();
        spike = 3'b000;
        chk("t7_idle_ignores_spike", {31'd0, bus.upd_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
